// File: rtl/port_bus_pkg.sv
// Shared definitions for the PicoBlaze-style port bus master: op encodings,
// FSM states and default bus widths.
package port_bus_pkg;

    localparam int unsigned PORT_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_WRK = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StStrobe = 2'd2,
        StIrqAck = 2'd3
    } state_e;

endpackage

// File: rtl/port_cmd_fifo.sv
// Command FIFO for port_bus_master: DEPTH entries of WIDTH bits, show-ahead
// read, full/empty flags, active-low asynchronous reset.
module port_cmd_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/port_bus_master.sv
// Autonomous kcpsm6-timed port bus initiator fed by a command FIFO.
// Optional interrupt acknowledge support: define PORT_BUS_MASTER_IRQ_EN.
module port_bus_master
    import port_bus_pkg::*;
#(
    parameter int unsigned PORT_W     = PORT_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [PORT_W-1:0] cmd_port,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [PORT_W-1:0] port_id,
    output logic [DATA_W-1:0] out_port,
    input  logic [DATA_W-1:0] in_port,
    output logic              write_strobe,
    output logic              k_write_strobe,
    output logic              read_strobe,
    input  logic              interrupt,
    output logic              interrupt_ack,
    output logic [7:0]        irq_count
);

    localparam int unsigned CMD_W = 2 + PORT_W + DATA_W;

    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [1:0]        head_op;
    logic [PORT_W-1:0] head_port;
    logic [DATA_W-1:0] head_data;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [PORT_W-1:0] port_id_q, port_id_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              try_pop;
    logic              irq_pending;

    // Held low while in reset so the bench/host never sees ready before release.
    assign cmd_ready = rst & ~fifo_full;

    port_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid & cmd_ready),
        .din   ({cmd_op, cmd_port, cmd_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_op   = fifo_dout[CMD_W-1 -: 2];
    assign head_port = fifo_dout[DATA_W +: PORT_W];
    assign head_data = fifo_dout[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        port_id_d  = port_id_q;
        out_port_d = out_port_q;
        fifo_pop   = 1'b0;
        try_pop    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (irq_pending) state_d = StIrqAck;
                else             try_pop = 1'b1;
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                if (irq_pending) begin
                    state_d = StIrqAck;
                end else begin
                    state_d = StIdle;
                    try_pop = 1'b1;
                end
            end
            StIrqAck: begin
                state_d = StIdle;
                try_pop = 1'b1;
            end
        endcase

        // Reserved ops are popped and dropped without touching the bus.
        if (try_pop && !fifo_empty) begin
            fifo_pop = 1'b1;
            if (head_op != OP_RSV) begin
                state_d   = StSetup;
                op_d      = head_op;
                port_id_d = head_port;
                if (head_op != OP_RD) out_port_d = head_data;
            end
        end
    end

    always_comb begin
        rsp_valid_d = (state_q == StStrobe) && (op_q == OP_RD);
        rsp_data_d  = rsp_valid_d ? in_port : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            op_q        <= OP_WR;
            port_id_q   <= '0;
            out_port_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            port_id_q   <= port_id_d;
            out_port_q  <= out_port_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign write_strobe   = (state_q == StStrobe) && (op_q == OP_WR);
    assign k_write_strobe = (state_q == StStrobe) && (op_q == OP_WRK);
    assign read_strobe    = (state_q == StStrobe) && (op_q == OP_RD);

    assign port_id   = port_id_q;
    assign out_port  = out_port_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle) || !fifo_empty;

`ifdef PORT_BUS_MASTER_IRQ_EN
    logic       int_q;
    logic       irq_pending_q;
    logic [7:0] irq_count_q;

    // A new edge during IRQ_ACK wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_q         <= 1'b0;
            irq_pending_q <= 1'b0;
            irq_count_q   <= '0;
        end else begin
            int_q         <= interrupt;
            irq_pending_q <= (interrupt & ~int_q) | (irq_pending_q & (state_q != StIrqAck));
            if (state_q == StIrqAck) irq_count_q <= irq_count_q + 8'd1;
        end
    end

    assign irq_pending   = irq_pending_q;
    assign interrupt_ack = (state_q == StIrqAck);
    assign irq_count     = irq_count_q;
`else
    logic unused_interrupt;

    assign unused_interrupt = interrupt;
    assign irq_pending      = 1'b0;
    assign interrupt_ack    = 1'b0;
    assign irq_count        = '0;
`endif

endmodule

// File: tb/tb_port_bus_master.sv
// Directed and randomized bench for port_bus_master against an ordered
// transaction scoreboard and a memory-backed port responder.
`timescale 1ns/1ps
module tb_port_bus_master;
    import port_bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_port = 8'h00;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic       interrupt = 1'b0;
    logic       interrupt_ack;
    logic [7:0] irq_count;

    port_bus_master #(
        .PORT_W     (8),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_port       (cmd_port),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .busy           (busy),
        .port_id        (port_id),
        .out_port       (out_port),
        .in_port        (in_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .interrupt      (interrupt),
        .interrupt_ack  (interrupt_ack),
        .irq_count      (irq_count)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign in_port = mem[port_id];

    typedef struct {
        logic [1:0] op;
        logic [7:0] port;
        logic [7:0] data;
    } txn_t;

    txn_t       exp_q[$];
    int         strobe_cyc[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         since_strobe = 100;
    int         strobes_seen = 0;
    logic       rsp_due = 1'b0;
    logic [7:0] rsp_exp = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: enqueue an accepted command, then check bus activity in order.
    task automatic tick();
        txn_t       t;
        txn_t       e;
        logic       acc;
        logic [1:0] obs_op;
        acc    = cmd_valid & cmd_ready;
        t.op   = cmd_op;
        t.port = cmd_port;
        t.data = cmd_data;
        @(posedge clk);
        if (acc && t.op != OP_RSV) exp_q.push_back(t);
        #1;
        cyc++;
        since_strobe++;
        check("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
        if (rsp_due) check("rsp_data", 32'(rsp_data), 32'(rsp_exp));
        rsp_due = 1'b0;
        if (write_strobe | k_write_strobe | read_strobe) begin
            check("strobe_onehot", 32'(write_strobe) + 32'(k_write_strobe) + 32'(read_strobe),
                  32'd1);
            check("strobe_spacing", 32'(since_strobe >= 2), 32'd1);
            check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            since_strobe = 0;
            strobes_seen++;
            strobe_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                obs_op = read_strobe ? OP_RD : (k_write_strobe ? OP_WRK : OP_WR);
                check("strobe_op", 32'(obs_op), 32'(e.op));
                check("strobe_port", 32'(port_id), 32'(e.port));
                if (e.op == OP_RD) begin
                    rsp_due = 1'b1;
                    rsp_exp = mem[e.port];
                end else begin
                    check("strobe_data", 32'(out_port), 32'(e.data));
                end
            end
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] port, input logic [7:0] data);
        logic r;
        r         = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_port  = port;
        cmd_data  = data;
        for (int i = 0; i < 50 && !r; i++) begin
            r = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("push_accepted", 32'(r), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) tick();
        tick();
        check({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, 32'({write_strobe, k_write_strobe, read_strobe}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_port_id"}, 32'(port_id), 32'd0);
        check({tag, "_out_port"}, 32'(out_port), 32'd0);
        check({tag, "_ack"}, 32'(interrupt_ack), 32'd0);
        check({tag, "_irq_count"}, 32'(irq_count), 32'd0);
    endtask

    initial begin
        int         base;
        int         t0;
        logic       saw_full;
        logic       r;
        int         idx;
        logic [1:0] rop;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[3] = 8'hA7;

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_release_ready", 32'(cmd_ready), 32'd1);

        // Single write: SETUP at N+2, strobe at N+3
        push(OP_WR, 8'h0A, 8'h5C);
        tick();
        check("wr_setup_port", 32'(port_id), 32'h0A);
        check("wr_setup_data", 32'(out_port), 32'h5C);
        check("wr_setup_nostrobe", 32'({write_strobe, k_write_strobe, read_strobe}), 32'd0);
        check("wr_setup_busy", 32'(busy), 32'd1);
        tick();
        check("wr_strobe", 32'(write_strobe), 32'd1);
        tick();
        check("wr_strobe_end", 32'(write_strobe), 32'd0);
        check("wr_done_idle", 32'(busy), 32'd0);

        // Single read: strobe at N+3, response at N+4, out_port held
        push(OP_RD, 8'h03, 8'hFF);
        tick();
        check("rd_setup_port", 32'(port_id), 32'h03);
        check("rd_outport_hold", 32'(out_port), 32'h5C);
        tick();
        check("rd_strobe", 32'(read_strobe), 32'd1);
        tick();
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(rsp_data), 32'hA7);
        tick();
        check("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
        check("rd_rsp_hold", 32'(rsp_data), 32'hA7);

        // Back-to-back: four pushes on consecutive edges, strobes every 2 cycles
        strobe_cyc.delete();
        cmd_valid = 1'b1;
        cmd_op = OP_WR;  cmd_port = 8'h01; cmd_data = 8'h11; tick();
        t0 = cyc;
        cmd_op = OP_WRK; cmd_port = 8'h02; cmd_data = 8'h22; tick();
        cmd_op = OP_RD;  cmd_port = 8'h04; cmd_data = 8'h00; tick();
        cmd_op = OP_WR;  cmd_port = 8'h05; cmd_data = 8'h55; tick();
        cmd_valid = 1'b0;
        drain("b2b");
        check("b2b_strobe_count", 32'(strobe_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < strobe_cyc.size(); i++)
            check("b2b_strobe_cycle", 32'(strobe_cyc[i] - t0), 32'(2 + 2 * i));

        // Fill: pushes outpace the 2-cycle drain; refused pushes carry poison
        saw_full = 1'b0;
        idx = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 60 && idx < 10; i++) begin
            r = cmd_ready;
            if (!r) saw_full = 1'b1;
            cmd_op   = OP_WR;
            cmd_port = r ? 8'(8'h40 + idx) : 8'hEE;
            cmd_data = r ? 8'(8'h80 + idx) : 8'hEE;
            tick();
            if (r) idx++;
        end
        cmd_valid = 1'b0;
        check("fill_saw_full", 32'(saw_full), 32'd1);
        check("fill_all_pushed", 32'(idx), 32'd10);
        drain("fill");

        // Reserved op is dropped, following write still runs
        base = strobes_seen;
        push(OP_RSV, 8'h33, 8'h33);
        push(OP_WR, 8'h06, 8'h66);
        drain("rsv");
        check("rsv_one_strobe", 32'(strobes_seen - base), 32'd1);

        // Reset during STROBE with commands still queued
        cmd_valid = 1'b1;
        cmd_op = OP_WR; cmd_port = 8'h07; cmd_data = 8'h77; tick();
        cmd_op = OP_WR; cmd_port = 8'h08; cmd_data = 8'h88; tick();
        cmd_op = OP_RD; cmd_port = 8'h09; cmd_data = 8'h00; tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !write_strobe; i++) tick();
        check("rst_reached_strobe", 32'(write_strobe), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        rsp_due = 1'b0;
        since_strobe = 100;
        @(negedge clk);
        rst = 1'b1;
        base = strobes_seen;
        repeat (8) tick();
        check("rst_queue_lost", 32'(strobes_seen - base), 32'd0);
        check("rst_after_idle", 32'(busy), 32'd0);

`ifdef PORT_BUS_MASTER_IRQ_EN
        // Interrupt raised during SETUP: write completes, then one ack
        push(OP_WR, 8'h10, 8'h01);
        tick();
        interrupt = 1'b1;
        tick();
        check("irq_write_strobe", 32'(write_strobe), 32'd1);
        check("irq_no_early_ack", 32'(interrupt_ack), 32'd0);
        tick();
        check("irq_ack", 32'(interrupt_ack), 32'd1);
        check("irq_count_before", 32'(irq_count), 32'd0);
        tick();
        check("irq_ack_pulse", 32'(interrupt_ack), 32'd0);
        check("irq_count_one", 32'(irq_count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("irq_held_no_ack", 32'(interrupt_ack), 32'd0);
        end
        check("irq_count_held", 32'(irq_count), 32'd1);
        interrupt = 1'b0;
        tick();
        interrupt = 1'b1;
        tick();
        tick();
        check("irq_idle_ack", 32'(interrupt_ack), 32'd1);
        tick();
        check("irq_count_two", 32'(irq_count), 32'd2);
        interrupt = 1'b0;
`else
        // Without the feature the interrupt input is ignored
        interrupt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("noirq_ack", 32'(interrupt_ack), 32'd0);
            check("noirq_count", 32'(irq_count), 32'd0);
        end
        interrupt = 1'b0;
        tick();
`endif

        // Random traffic against the scoreboard
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            rop = 2'($urandom_range(0, 3));
            push(rop, 8'($urandom), 8'($urandom));
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
